axi_burst_master: RTL and testbench

- Single-outstanding AXI4 master. Converts a simple command/stream interface into INCR bursts on a full AXI4 bus.
- Used as the initiator that drives axi_ram_sim and SoC memory slaves in testbenches and DMA-style helpers.
- Issues one read or write burst per command. Reports the completion status.

---
 rtl/axi_burst_master_if.sv | 119 +++++++++++
 rtl/axi_burst_master.sv | 158 +++++++++++++++
 tb/tb_axi_burst_master.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_master_if.sv
// Command, stream, completion and AXI4 master signals for axi_burst_master.
// The master modport is the burst master's view; slave is the peer's view.
interface axi_burst_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [ID_WIDTH-1:0]   cmd_id;

  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_valid;
  logic                  wr_ready;

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;
  logic                  rd_valid;
  logic                  rd_ready;

  logic                  done_valid;
  logic [1:0]            done_resp;
  logic                  busy;

  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awlock;
  logic [3:0]            m_axi_awcache;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  logic [ID_WIDTH-1:0]   m_axi_arid;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arlock;
  logic [3:0]            m_axi_arcache;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;

  logic [ID_WIDTH-1:0]   m_axi_rid;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
    output cmd_ready,
    input  wr_data, wr_strb, wr_valid,
    output wr_ready,
    output rd_data, rd_last, rd_valid,
    input  rd_ready,
    output done_valid, done_resp, busy,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
    output m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
    output m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
    output m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
    output m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    input  m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id,
    input  cmd_ready,
    output wr_data, wr_strb, wr_valid,
    input  wr_ready,
    input  rd_data, rd_last, rd_valid,
    output rd_ready,
    input  done_valid, done_resp, busy,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
    input  m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot,
    input  m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
    input  m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
    input  m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    output m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master driven by a command/stream port.
// Optional 4 KB boundary rejection: define AXI_BURST_MASTER_4K_CHECK_EN.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input logic                clk,
  input logic                rst,
  axi_burst_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  localparam logic [2:0] SIZE = 3'($clog2(STRB_WIDTH));

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [1:0]            r_status;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_w_hs;
  logic                  w_r_hs;
  logic                  w_oob;
  logic [1:0]            w_rstat;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_accept = bus.cmd_valid && bus.cmd_ready;
  assign w_last   = (r_cnt == r_len);
  assign w_w_hs   = (r_state == S_W) && bus.wr_valid
                  && bus.m_axi_wready;
  assign w_r_hs   = (r_state == S_R) && bus.m_axi_rvalid
                  && bus.rd_ready;

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
  logic [31:0] w_end;
  assign w_end = 32'(bus.cmd_addr[11:0])
               + (32'(bus.cmd_len) + 32'd1) * 32'(STRB_WIDTH);
  assign w_oob = (w_end > 32'd4096);
`else
  assign w_oob = 1'b0;
`endif

  // Worst-so-far read status; bad rid or misplaced rlast is a SLVERR.
  always_comb begin
    w_rstat = (bus.m_axi_rresp > r_status) ? bus.m_axi_rresp
                                           : r_status;
    if ((bus.m_axi_rid != r_id) || (bus.m_axi_rlast != w_last)) begin
      if (w_rstat < 2'b10) w_rstat = 2'b10;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_oob)              w_next = S_DONE;
          else if (bus.cmd_write) w_next = S_AW;
          else                    w_next = S_AR;
        end
      end
      S_AW:    if (bus.m_axi_awready) w_next = S_W;
      S_W:     if (w_w_hs && w_last)  w_next = S_B;
      S_B:     if (bus.m_axi_bvalid)  w_next = S_DONE;
      S_AR:    if (bus.m_axi_arready) w_next = S_R;
      S_R:     if (w_r_hs && w_last)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, beat counter and completion status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_status <= 2'b00;
    end else begin
      if (w_accept) begin
        r_addr   <= bus.cmd_addr;
        r_len    <= bus.cmd_len;
        r_id     <= bus.cmd_id;
        r_cnt    <= '0;
        r_status <= w_oob ? 2'b10 : 2'b00;
      end
      if (w_w_hs || w_r_hs) r_cnt <= r_cnt + 8'd1;
      if ((r_state == S_AR) && bus.m_axi_arready) r_status <= 2'b00;
      if (w_r_hs) r_status <= w_rstat;
      if ((r_state == S_B) && bus.m_axi_bvalid) begin
        r_status <= (bus.m_axi_bid != r_id) ? 2'b10
                                            : bus.m_axi_bresp;
      end
    end
  end

  assign w_wdata = bus.wr_data;

  // Handshake and status outputs decoded from the state.
  always_comb begin
    bus.cmd_ready     = (r_state == S_IDLE) && !rst;
    bus.busy          = (r_state == S_AW) || (r_state == S_W)
                     || (r_state == S_B)  || (r_state == S_AR)
                     || (r_state == S_R);
    bus.m_axi_awvalid = (r_state == S_AW);
    bus.m_axi_wvalid  = (r_state == S_W) && bus.wr_valid;
    bus.wr_ready      = (r_state == S_W) && bus.m_axi_wready;
    bus.m_axi_wlast   = (r_state == S_W) && w_last;
    bus.m_axi_bready  = (r_state == S_B);
    bus.m_axi_arvalid = (r_state == S_AR);
    bus.m_axi_rready  = (r_state == S_R) && bus.rd_ready;
    bus.rd_valid      = (r_state == S_R) && bus.m_axi_rvalid;
    bus.rd_last       = (r_state == S_R) && w_last;
    bus.done_valid    = (r_state == S_DONE);
    bus.done_resp     = (r_state == S_DONE) ? r_status : 2'b00;
  end

  assign bus.m_axi_awid    = r_id;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awlen   = r_len;
  assign bus.m_axi_awsize  = SIZE;
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = 4'b0011;
  assign bus.m_axi_awprot  = 3'b000;

  assign bus.m_axi_wdata   = w_wdata;
  assign bus.m_axi_wstrb   = bus.wr_strb;

  assign bus.m_axi_arid    = r_id;
  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arlen   = r_len;
  assign bus.m_axi_arsize  = SIZE;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arlock  = 1'b0;
  assign bus.m_axi_arcache = 4'b0011;
  assign bus.m_axi_arprot  = 3'b000;

  assign bus.rd_data       = bus.m_axi_rdata;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with an inline AXI4 RAM slave,
// a reference memory and write/read scoreboard queues.
module tb_axi_burst_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_burst_master_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .STRB_WIDTH(SW), .ID_WIDTH(IW)
  ) bus ();

  axi_burst_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .STRB_WIDTH(SW), .ID_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_acc = 0;
  int done_cnt = 0;
  int aw_count = 0;

  logic [31:0] s_mem   [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] wexp[$];
  logic [31:0] rexp[$];

  bit s_bp = 1'b0;
  bit s_bid_bad = 1'b0;
  int s_rerr_beat = -1;

  logic [31:0] cur_addr = '0;
  logic [7:0]  cur_len = '0;
  logic [7:0]  cur_id = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a, input int b);
    return int'(((a >> 2) + 32'(b)) & 32'h3FF);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (bus.done_valid) done_cnt++;
    end
  end

  // AXI4 RAM slave: drives at negedge, observes handshakes 3 ns later.
  logic [31:0] sw_addr = '0, sr_addr = '0;
  logic [7:0]  sw_id = '0, sr_id = '0;
  int sw_beat = 0, sw_len = 0, sr_beat = 0, sr_len = 0;
  bit sb_pend = 0, sr_act = 0, sr_vld = 0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      s_mem[i] = '0;
      ref_mem[i] = '0;
    end
    bus.m_axi_awready = 0; bus.m_axi_wready = 0;
    bus.m_axi_arready = 0; bus.m_axi_bvalid = 0;
    bus.m_axi_bid = '0; bus.m_axi_bresp = '0;
    bus.m_axi_rvalid = 0; bus.m_axi_rid = '0;
    bus.m_axi_rdata = '0; bus.m_axi_rresp = '0;
    bus.m_axi_rlast = 0;
    forever begin
      @(negedge clk);
      bus.m_axi_awready = s_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_axi_wready  = s_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_axi_arready = s_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_axi_bvalid = sb_pend;
      bus.m_axi_bid = s_bid_bad ? ~sw_id : sw_id;
      bus.m_axi_bresp = 2'b00;
      if (sr_act && !sr_vld)
        sr_vld = s_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.m_axi_rvalid = sr_vld;
      bus.m_axi_rid = sr_id;
      bus.m_axi_rdata = s_mem[widx(sr_addr, sr_beat)];
      bus.m_axi_rresp = (sr_beat == s_rerr_beat) ? 2'b10 : 2'b00;
      bus.m_axi_rlast = sr_act && (sr_beat == sr_len);
      #3;
      if (rst) begin
        sb_pend = 0; sr_act = 0; sr_vld = 0;
      end else begin
        if (bus.m_axi_awvalid) begin
          check("aw_fields",
                {bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awid},
                {cur_addr, cur_len, cur_id});
          if (bus.m_axi_awready) begin
            check("aw_const",
                  {bus.m_axi_awsize, bus.m_axi_awburst,
                   bus.m_axi_awlock, bus.m_axi_awcache,
                   bus.m_axi_awprot},
                  {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
            aw_count++;
            sw_addr = bus.m_axi_awaddr;
            sw_len = int'(bus.m_axi_awlen);
            sw_id = bus.m_axi_awid;
            sw_beat = 0;
          end
        end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          check("wlast", bus.m_axi_wlast, sw_beat == sw_len);
          check("w_queue", wexp.size() > 0, 1'b1);
          if (wexp.size() > 0)
            check("wdata", bus.m_axi_wdata, wexp.pop_front());
          for (int b = 0; b < SW; b++)
            if (bus.m_axi_wstrb[b])
              s_mem[widx(sw_addr, sw_beat)][8*b +: 8] =
                bus.m_axi_wdata[8*b +: 8];
          sw_beat++;
          if (sw_beat > sw_len) sb_pend = 1;
        end
        if (bus.m_axi_bvalid && bus.m_axi_bready) sb_pend = 0;
        if (bus.m_axi_arvalid) begin
          check("ar_fields",
                {bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arid},
                {cur_addr, cur_len, cur_id});
          if (bus.m_axi_arready) begin
            check("ar_const",
                  {bus.m_axi_arsize, bus.m_axi_arburst,
                   bus.m_axi_arlock, bus.m_axi_arcache,
                   bus.m_axi_arprot},
                  {3'd2, 2'b01, 1'b0, 4'b0011, 3'b000});
            sr_addr = bus.m_axi_araddr;
            sr_len = int'(bus.m_axi_arlen);
            sr_id = bus.m_axi_arid;
            sr_beat = 0;
            sr_act = 1;
          end
        end
        if (bus.m_axi_rvalid && bus.m_axi_rready) begin
          sr_vld = 0;
          sr_beat++;
          if (sr_beat > sr_len) sr_act = 0;
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a,
                       input logic [7:0] l, input logic [7:0] id);
    int n = 0;
    cur_addr = a; cur_len = l; cur_id = id;
    @(negedge clk);
    bus.cmd_valid = 1; bus.cmd_write = wr;
    bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_id = id;
    #3;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk); #3; n++;
    end
    check("cmd_accept", bus.cmd_ready, 1'b1);
    t_acc = cyc;
  endtask

  task automatic wait_done(input logic [1:0] er, input string tag,
                           output int lat);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      bus.cmd_valid = 0; bus.wr_valid = 0; bus.rd_ready = 0;
      #3;
      seen = bus.done_valid;
      n++;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_resp"}, bus.done_resp, er);
    lat = cyc - t_acc;
    @(negedge clk); #3;
    check({tag, "_pulse"}, {bus.done_valid, bus.busy}, 2'b00);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] l,
                          input logic [7:0] id, input logic [3:0] strb,
                          input logic [31:0] base, input bit bp,
                          input logic [1:0] er, input string tag);
    int beat = 0, n = 0, lat;
    for (int i = 0; i <= int'(l); i++) begin
      logic [31:0] d;
      d = base + 32'(i);
      wexp.push_back(d);
      for (int b = 0; b < SW; b++)
        if (strb[b]) ref_mem[widx(a, i)][8*b +: 8] = d[8*b +: 8];
    end
    issue(1'b1, a, l, id);
    while (beat <= int'(l) && n < 5000) begin
      @(negedge clk);
      bus.cmd_valid = 0;
      bus.wr_valid = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.wr_data = base + 32'(beat);
      bus.wr_strb = strb;
      #3;
      check({tag, "_busy"}, bus.busy, 1'b1);
      if (bus.wr_valid && bus.wr_ready) beat++;
      n++;
    end
    check({tag, "_beats"}, beat, int'(l) + 1);
    wait_done(er, tag, lat);
    if (!bp) check({tag, "_latency"}, lat, int'(l) + 4);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] l,
                         input logic [7:0] id, input bit bp,
                         input logic [1:0] er, input string tag);
    int beat = 0, n = 0, lat;
    for (int i = 0; i <= int'(l); i++)
      rexp.push_back(ref_mem[widx(a, i)]);
    issue(1'b0, a, l, id);
    while (beat <= int'(l) && n < 5000) begin
      @(negedge clk);
      bus.cmd_valid = 0;
      bus.rd_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      #3;
      if (bus.rd_valid && bus.rd_ready) begin
        check({tag, "_rd_last"}, bus.rd_last, beat == int'(l));
        check({tag, "_r_queue"}, rexp.size() > 0, 1'b1);
        if (rexp.size() > 0)
          check({tag, "_rd_data"}, bus.rd_data, rexp.pop_front());
        beat++;
      end
      n++;
    end
    check({tag, "_beats"}, beat, int'(l) + 1);
    wait_done(er, tag, lat);
    if (!bp) check({tag, "_latency"}, lat, int'(l) + 3);
  endtask

  initial begin
    int beat, n, d0, lat;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0;
    bus.cmd_len = '0; bus.cmd_id = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.wr_strb = '0;
    bus.rd_ready = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    #3;
    check("reset_state",
          {bus.cmd_ready, bus.busy, bus.done_valid, bus.done_resp,
           bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
           bus.m_axi_arvalid, bus.m_axi_rready},
          10'b0);
    @(negedge clk);
    rst = 0;
    #3;
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);

    do_write(32'h100, 8'd3, 8'h11, 4'hF, 32'hA0, 0, 2'b00, "wr4");
    do_read(32'h100, 8'd3, 8'h12, 0, 2'b00, "rd4");

    do_write(32'h0, 8'd0, 8'h21, 4'h3, 32'hDEADBEEF, 0, 2'b00, "wr1");
    check("ref_beef", ref_mem[0], 32'h0000BEEF);
    do_read(32'h0, 8'd0, 8'h22, 0, 2'b00, "rd1");

    s_bp = 1;
    do_write(32'h40, 8'd15, 8'h31, 4'hF, 32'h1000, 1, 2'b00, "wr_bp");
    do_read(32'h40, 8'd15, 8'h32, 1, 2'b00, "rd_bp");
    s_bp = 0;

    s_rerr_beat = 2;
    do_read(32'h100, 8'd3, 8'h41, 0, 2'b10, "rd_rerr");
    s_rerr_beat = -1;

    s_bid_bad = 1;
    do_write(32'h80, 8'd1, 8'h51, 4'hF, 32'h7700, 0, 2'b10, "wr_bid");
    s_bid_bad = 0;

    d0 = done_cnt;
    for (int i = 0; i < 16; i++) wexp.push_back(32'h9000 + 32'(i));
    issue(1'b1, 32'h300, 8'd15, 8'h61);
    beat = 0; n = 0;
    while (beat < 5 && n < 500) begin
      @(negedge clk);
      bus.cmd_valid = 0;
      bus.wr_valid = 1; bus.wr_data = 32'h9000 + 32'(beat);
      bus.wr_strb = 4'hF;
      #3;
      if (bus.wr_valid && bus.wr_ready) beat++;
      n++;
    end
    check("abort_beats", beat, 5);
    @(negedge clk);
    bus.wr_valid = 1; bus.wr_data = 32'h9005; rst = 1;
    #3;
    @(negedge clk);
    bus.wr_valid = 0;
    #3;
    check("abort_valids",
          {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
           bus.m_axi_arvalid, bus.m_axi_rready, bus.done_valid,
           bus.busy},
          7'b0);
    check("abort_cmd_ready", bus.cmd_ready, 1'b0);
    wexp.delete();
    @(negedge clk);
    rst = 0;
    #3;
    check("abort_idle", bus.cmd_ready, 1'b1);
    repeat (3) @(negedge clk);
    #3;
    check("abort_no_done", done_cnt, d0);

    do_write(32'h200, 8'd1, 8'h71, 4'hF, 32'hC0C0, 0, 2'b00, "wr_post");
    do_read(32'h200, 8'd1, 8'h72, 0, 2'b00, "rd_post");

    do_write(32'h400, 8'd255, 8'h81, 4'hF, 32'h5000_0000, 0, 2'b00,
             "wr256");
    do_read(32'h400, 8'd255, 8'h82, 0, 2'b00, "rd256");

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    d0 = aw_count;
    issue(1'b1, 32'hFF8, 8'd3, 8'h91);
    wait_done(2'b10, "oob", lat);
    check("oob_no_aw", aw_count, d0);
    do_write(32'hFF0, 8'd3, 8'h92, 4'hF, 32'hE0, 0, 2'b00, "wr_4k_ok");
    do_read(32'hFF0, 8'd3, 8'h93, 0, 2'b00, "rd_4k_ok");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
